// File: rtl/handshake_pkg.sv
// rtl/handshake_pkg.sv - shared definitions for the pulse handshake transmitter
//
// Purpose : FSM state encoding and the default ack synchronizer depth shared
//           by pulse_handshake_tx and its bench.
// Contents: hs_state_e      - IDLE / REQ / WAIT_LOW four-phase states
//           SYNC_STAGES_DEF - default flop count of the ack synchronizer
package handshake_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_LOW = 2'd2
  } hs_state_e;

  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - multi-flop level synchronizer with synchronous clear
//
// Purpose : brings an asynchronous level into the clk domain through STAGES
//           back-to-back flops with no logic between them.
// Ports   : clk - destination clock
//           clr - synchronous active-high clear, zeroes every stage
//           d   - asynchronous input level
//           q   - synchronized level (last stage)
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pulse_handshake_tx.sv
// rtl/pulse_handshake_tx.sv - event-to-four-phase-handshake transmitter with event queue
//
// Purpose : turns single-cycle event strobes into four-phase req/ack
//           handshakes toward another clock domain. Events arriving while a
//           handshake is in flight are counted and launched later.
// Ports   : clk         - clock, all state on its rising edge
//           clr         - synchronous active-high reset
//           event_in    - single-cycle event strobe
//           ack_async   - acknowledge level from the receiving domain
//           req_out     - registered request level, high exactly in REQ
//           busy        - FSM not idle or events still queued
//           pending     - number of queued, unlaunched events
//           overflow    - sticky: an event was dropped at a full counter
//           timeout_err - (ACK_TIMEOUT_EN only) sticky ack timeout flag
// Config  : define ACK_TIMEOUT_EN to add the ack timeout counter and the
//           timeout_err port; otherwise the FSM waits on ack indefinitely.
module pulse_handshake_tx
  import handshake_pkg::*;
#(
  parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter int CNT_W          = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             event_in,
  input  logic             ack_async,
  output logic             req_out,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             overflow
`ifdef ACK_TIMEOUT_EN
  ,
  output logic             timeout_err
`endif
);

  // Elaboration-time parameter legality checks.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("pulse_handshake_tx: SYNC_STAGES must be 2..4");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("pulse_handshake_tx: TIMEOUT_CYCLES must be at least 1");
  end

  hs_state_e        state_q, state_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             overflow_q, overflow_d;
  logic             req_q;
  logic             ack_s;
  logic             has_work;
  logic             launch;
  logic             tmo_hit;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk (clk),
    .clr (clr),
    .d   (ack_async),
    .q   (ack_s)
  );

  // Something to send: a fresh event this cycle or one already queued.
  assign has_work = event_in || (pending_q != '0);

`ifdef ACK_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_err_q, tmo_err_d;

  // The counter holds the number of edges spent in the current REQ or
  // WAIT_LOW visit; the edge that would make it TIMEOUT_CYCLES aborts.
  assign tmo_hit = (state_q != ST_IDLE) &&
                   (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    tmo_err_d = tmo_err_q;
    if ((state_d != state_q) && (state_d != ST_IDLE)) begin
      tmo_cnt_d = '0;
    end else if (state_q != ST_IDLE && state_d != ST_IDLE) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end else begin
      tmo_cnt_d = '0;
    end
    if (tmo_hit) begin
      tmo_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign timeout_err = tmo_err_q;
`else
  assign tmo_hit = 1'b0;
`endif

  // Next-state logic. A timeout takes priority over a same-cycle ack change.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (has_work) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (tmo_hit) begin
          state_d = ST_IDLE;
        end else if (ack_s) begin
          state_d = ST_WAIT_LOW;
        end
      end
      ST_WAIT_LOW: begin
        if (tmo_hit) begin
          state_d = ST_IDLE;
        end else if (!ack_s) begin
          state_d = has_work ? ST_REQ : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign launch = (state_d == ST_REQ) && (state_q != ST_REQ);

  // Queue bookkeeping. A launch takes the same-cycle event if there is one,
  // otherwise it pops a queued event; launches without an event only occur
  // with pending > 0, so the decrement cannot wrap.
  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q;
    if (launch) begin
      if (!event_in) begin
        pending_d = pending_q - CNT_W'(1);
      end
    end else if (event_in) begin
      if (pending_q == '1) begin
        overflow_d = 1'b1;
      end else begin
        pending_d = pending_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= (state_d == ST_REQ);
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign req_out  = req_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != ST_IDLE) || (pending_q != '0);

endmodule

// File: tb/tb_pulse_handshake_tx.sv
// tb/tb_pulse_handshake_tx.sv - directed self-checking bench for pulse_handshake_tx
module tb_pulse_handshake_tx;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  // dut1: CNT_W=4, dut2: CNT_W=2
  logic       ev1 = 1'b0, ack1 = 1'b0, req1, busy1, ovf1;
  logic [3:0] pend1;
  logic       ev2 = 1'b0, ack2 = 1'b0, req2, busy2, ovf2;
  logic [1:0] pend2;
`ifdef ACK_TIMEOUT_EN
  logic       tmo1, tmo2;
`endif

  // Ack responder model: ack follows req 3 cycles after req changes.
  logic en1 = 1'b1, en2 = 1'b1;
  int   rc1 = 0, rc2 = 0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pulse_handshake_tx #(.SYNC_STAGES(2), .CNT_W(4), .TIMEOUT_CYCLES(10)) dut1 (
    .clk(clk), .clr(clr), .event_in(ev1), .ack_async(ack1),
    .req_out(req1), .busy(busy1), .pending(pend1), .overflow(ovf1)
`ifdef ACK_TIMEOUT_EN
    , .timeout_err(tmo1)
`endif
  );

  pulse_handshake_tx #(.SYNC_STAGES(2), .CNT_W(2), .TIMEOUT_CYCLES(10)) dut2 (
    .clk(clk), .clr(clr), .event_in(ev2), .ack_async(ack2),
    .req_out(req2), .busy(busy2), .pending(pend2), .overflow(ovf2)
`ifdef ACK_TIMEOUT_EN
    , .timeout_err(tmo2)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
    if (clr) begin
      ack1 = 1'b0; ack2 = 1'b0; rc1 = 0; rc2 = 0;
    end else begin
      if (en1 && (req1 !== ack1)) begin
        rc1++;
        if (rc1 == 3) begin ack1 = ~ack1; rc1 = 0; end
      end else rc1 = 0;
      if (en2 && (req2 !== ack2)) begin
        rc2++;
        if (rc2 == 3) begin ack2 = ~ack2; rc2 = 0; end
      end else rc2 = 0;
    end
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;
    checks++; if (req1 !== 1'b0) begin errors++; $display("FAIL reset_req1: got %b want 0", req1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy1: got %b want 0", busy1); end
    checks++; if (pend1 !== 4'd0) begin errors++; $display("FAIL reset_pend1: got %0d want 0", pend1); end
    checks++; if (ovf1 !== 1'b0) begin errors++; $display("FAIL reset_ovf1: got %b want 0", ovf1); end
    checks++; if (req2 !== 1'b0 || busy2 !== 1'b0 || pend2 !== 2'd0 || ovf2 !== 1'b0) begin
      errors++; $display("FAIL reset_dut2: got req=%b busy=%b pend=%0d ovf=%b want all 0", req2, busy2, pend2, ovf2);
    end
`ifdef ACK_TIMEOUT_EN
    checks++; if (tmo1 !== 1'b0) begin errors++; $display("FAIL reset_tmo1: got %b want 0", tmo1); end
`endif
  endtask

  task automatic test_single();
    logic r [0:10];
    logic b [0:10];
    do_clr();
    ev1 = 1'b1;
    tick();
    ev1 = 1'b0;
    checks++; if (req1 !== 1'b1) begin errors++; $display("FAIL single_latency_req: got %b want 1", req1); end
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy1); end
    checks++; if (pend1 !== 4'd0) begin errors++; $display("FAIL single_pend_launch: got %0d want 0", pend1); end
    for (int i = 1; i <= 10; i++) begin
      tick();
      r[i] = req1;
      b[i] = busy1;
    end
    checks++; if (r[4] !== 1'b1) begin errors++; $display("FAIL single_req_hold: got %b want 1", r[4]); end
    checks++; if (r[5] !== 1'b0) begin errors++; $display("FAIL single_req_drop: got %b want 0", r[5]); end
    checks++; if (b[9] !== 1'b1) begin errors++; $display("FAIL single_busy_waitlow: got %b want 1", b[9]); end
    checks++; if (b[10] !== 1'b0) begin errors++; $display("FAIL single_idle: got %b want 0", b[10]); end
    checks++; if (pend1 !== 4'd0) begin errors++; $display("FAIL single_pend_end: got %0d want 0", pend1); end
  endtask

  task automatic test_burst();
    int pulses = 0;
    int maxp = 0;
    logic prev;
    int budget;
    do_clr();
    prev = req1;
    for (int i = 0; i < 5; i++) begin
      ev1 = 1'b1;
      tick();
      if (req1 && !prev) pulses++;
      prev = req1;
      if (int'(pend1) > maxp) maxp = int'(pend1);
    end
    ev1 = 1'b0;
    budget = 0;
    while (busy1 && budget < 300) begin
      tick();
      budget++;
      if (req1 && !prev) pulses++;
      prev = req1;
      if (int'(pend1) > maxp) maxp = int'(pend1);
    end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL burst_timeout: busy=%b after %0d cycles want 0", busy1, budget); end
    checks++; if (maxp != 4) begin errors++; $display("FAIL burst_peak: got %0d want 4", maxp); end
    checks++; if (pulses != 5) begin errors++; $display("FAIL burst_pulses: got %0d want 5", pulses); end
    checks++; if (pend1 !== 4'd0) begin errors++; $display("FAIL burst_pend_end: got %0d want 0", pend1); end
  endtask

  task automatic test_simultaneous();
    int budget;
    do_clr();
    for (int i = 0; i < 3; i++) begin
      ev1 = 1'b1;
      tick();
    end
    ev1 = 1'b0;
    for (int i = 3; i <= 9; i++) tick();
    checks++; if (req1 !== 1'b0) begin errors++; $display("FAIL simul_waitlow_req: got %b want 0", req1); end
    checks++; if (pend1 !== 4'd2) begin errors++; $display("FAIL simul_pend_before: got %0d want 2", pend1); end
    ev1 = 1'b1;
    tick();
    ev1 = 1'b0;
    checks++; if (req1 !== 1'b1) begin errors++; $display("FAIL simul_relaunch: got %b want 1", req1); end
    checks++; if (pend1 !== 4'd2) begin errors++; $display("FAIL simul_pend_after: got %0d want 2", pend1); end
    budget = 0;
    while (busy1 && budget < 300) begin tick(); budget++; end
    checks++; if (busy1 !== 1'b0 || pend1 !== 4'd0) begin
      errors++; $display("FAIL simul_drain: got busy=%b pend=%0d want 0 0", busy1, pend1);
    end
  endtask

  task automatic test_reset_mid();
    do_clr();
    for (int i = 0; i < 4; i++) begin
      ev1 = 1'b1;
      tick();
    end
    ev1 = 1'b0;
    checks++; if (req1 !== 1'b1 || pend1 !== 4'd3) begin
      errors++; $display("FAIL rstmid_setup: got req=%b pend=%0d want 1 3", req1, pend1);
    end
    clr = 1'b1;
    ev1 = 1'b1;
    tick();
    clr = 1'b0;
    ev1 = 1'b0;
    checks++; if (req1 !== 1'b0) begin errors++; $display("FAIL rstmid_req: got %b want 0", req1); end
    checks++; if (pend1 !== 4'd0) begin errors++; $display("FAIL rstmid_pend: got %0d want 0", pend1); end
    checks++; if (ovf1 !== 1'b0) begin errors++; $display("FAIL rstmid_ovf: got %b want 0", ovf1); end
    for (int i = 0; i < 3; i++) tick();
    checks++; if (req1 !== 1'b0 || busy1 !== 1'b0) begin
      errors++; $display("FAIL rstmid_discard: got req=%b busy=%b want 0 0", req1, busy1);
    end
  endtask

  task automatic test_saturation();
    int pulses = 0;
    logic prev;
    int budget;
    do_clr();
    en2 = 1'b0;
    prev = req2;
    for (int i = 0; i < 6; i++) begin
      ev2 = 1'b1;
      tick();
      if (req2 && !prev) pulses++;
      prev = req2;
      if (i == 3) begin
        checks++; if (pend2 !== 2'd3 || ovf2 !== 1'b0) begin
          errors++; $display("FAIL sat_full_no_ovf: got pend=%0d ovf=%b want 3 0", pend2, ovf2);
        end
      end
    end
    ev2 = 1'b0;
    checks++; if (pend2 !== 2'd3) begin errors++; $display("FAIL sat_pend: got %0d want 3", pend2); end
    checks++; if (ovf2 !== 1'b1) begin errors++; $display("FAIL sat_ovf: got %b want 1", ovf2); end
    en2 = 1'b1;
    budget = 0;
    while (busy2 && budget < 300) begin
      tick();
      budget++;
      if (req2 && !prev) pulses++;
      prev = req2;
    end
    checks++; if (pulses != 4) begin errors++; $display("FAIL sat_pulses: got %0d want 4", pulses); end
    checks++; if (busy2 !== 1'b0 || ovf2 !== 1'b1) begin
      errors++; $display("FAIL sat_end: got busy=%b ovf=%b want 0 1", busy2, ovf2);
    end
  endtask

`ifdef ACK_TIMEOUT_EN
  task automatic test_timeout();
    do_clr();
    en1 = 1'b0;
    ev1 = 1'b1;
    tick();
    tick();
    ev1 = 1'b0;
    for (int i = 2; i <= 9; i++) tick();
    checks++; if (req1 !== 1'b1 || tmo1 !== 1'b0) begin
      errors++; $display("FAIL tmo_before: got req=%b err=%b want 1 0", req1, tmo1);
    end
    tick();
    checks++; if (req1 !== 1'b0) begin errors++; $display("FAIL tmo_req_drop: got %b want 0", req1); end
    checks++; if (tmo1 !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b want 1", tmo1); end
    checks++; if (pend1 !== 4'd1) begin errors++; $display("FAIL tmo_pend_kept: got %0d want 1", pend1); end
    tick();
    checks++; if (req1 !== 1'b1 || pend1 !== 4'd0 || tmo1 !== 1'b1) begin
      errors++; $display("FAIL tmo_relaunch: got req=%b pend=%0d err=%b want 1 0 1", req1, pend1, tmo1);
    end
    do_clr();
    checks++; if (tmo1 !== 1'b0) begin errors++; $display("FAIL tmo_clr: got %b want 0", tmo1); end
    en1 = 1'b1;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_simultaneous();
    test_reset_mid();
    test_saturation();
`ifdef ACK_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_handshake_tx.md
PULSE_HANDSHAKE_TX -- requirements
Module: pulse_handshake_tx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the flop count of the ack synchronizer (legal range 2..4).
REQ-002 SHALL have parameter CNT_W, default 4, giving the width of the pending-event counter.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the ack timeout in clk cycles (used only with the REQ-021 macro).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port clr, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port event_in, input, 1 bit: single-cycle event strobe, clk domain.
REQ-007 SHALL have port ack_async, input, 1 bit: acknowledge level from the receiving clock domain, asynchronous to clk.
REQ-008 SHALL have port req_out, output, 1 bit: registered request level to the receiving domain.
REQ-009 SHALL have port busy, output, 1 bit: high whenever state is not IDLE or pending count is nonzero.
REQ-010 SHALL have port pending, output, CNT_W bits: number of queued, unlaunched events.
REQ-011 SHALL have port overflow, output, 1 bit: sticky flag for an event lost at a saturated counter.

Function
REQ-012 SHALL pass ack_async through SYNC_STAGES flops; ack_s is the last stage; no logic is placed between the stages.
REQ-013 SHALL implement a 4-phase FSM with states IDLE, REQ, WAIT_LOW; req_out is registered and equals 1 exactly while the state is REQ.
REQ-014 IDLE: if event_in=1, or pending>0, go to REQ on the next edge; otherwise stay in IDLE.
REQ-015 REQ: stay until ack_s=1, then go to WAIT_LOW.
REQ-016 WAIT_LOW: stay until ack_s=0, then go to REQ if pending>0 or event_in=1, else go to IDLE.
REQ-017 Launch means any transition into REQ. A launch consumes the event_in of the same cycle if present; otherwise it decrements pending by 1.
REQ-018 An event_in that does not launch SHALL increment pending; an increment and a decrement in the same cycle leave pending unchanged.
REQ-019 An event_in at pending = 2^CNT_W-1 with no launch that cycle SHALL leave pending unchanged and set overflow; overflow clears only on clr.
REQ-020 Latency: event_in high at edge N in IDLE with pending=0 -> req_out=1 after edge N; one handshake completes in a minimum of 2*SYNC_STAGES+2 cycles.

Configuration
REQ-021 With ACK_TIMEOUT_EN defined, the block SHALL add output timeout_err (1 bit, sticky until clr) and a cycle counter cleared on entry to REQ or WAIT_LOW.
REQ-022 If that counter reaches TIMEOUT_CYCLES while in REQ or WAIT_LOW, the FSM SHALL go to IDLE, req_out shall be 0, timeout_err shall be set, and pending shall be retained.
REQ-023 Without ACK_TIMEOUT_EN, there SHALL be no timeout_err port and no timeout counter, and the FSM waits on ack_s indefinitely.

Reset
REQ-024 clr=1 at an edge SHALL set state=IDLE, req_out=0, pending=0, overflow=0, all synchronizer flops=0, timeout_err=0 and the timeout counter=0; clr overrides event_in.
REQ-025 clr asserted mid-handshake SHALL drop req_out on the next edge, and queued events are discarded.

Structure
REQ-026 The FSM state encoding and the SYNC_STAGES default SHALL live in shared package handshake_pkg.
REQ-027 The ack synchronizer SHALL be the separate sub-module sync_chain (parameter STAGES, ports clk, clr, d, q).

Verification
REQ-028 Single event: clr, then event_in 1 cycle; ack_async rises 3 cycles after req_out, falls 3 cycles after req_out falls -> req_out high then low, returns to IDLE, busy=0, pending=0.
REQ-029 Burst: 5 back-to-back events during one handshake -> pending peaks at 4; exactly 5 req_out pulses follow; pending ends at 0.
REQ-030 Saturation with CNT_W=2, ack held low: 6 events -> pending=3, overflow=1; after ack toggling, 4 req_out pulses total.
REQ-031 Simultaneous: event_in coincides with the WAIT_LOW->REQ launch while pending=2 -> pending stays 2.
REQ-032 Reset mid-handshake: clr while state is REQ with pending=3 -> req_out=0 next cycle, pending=0, overflow=0.
REQ-033 ACK_TIMEOUT_EN, TIMEOUT_CYCLES=10, ack tied 0: one event -> req_out drops and timeout_err=1 on cycle 10 after entering REQ.
